// File: rtl/cve2_rvfi_trace_fifo.sv
// RVFI retirement capture buffer with stream, ring and trigger modes.
// Retired-instruction records go into a Depth-entry first-word-fall-through FIFO
// and drain over a valid/ready port. When the FIFO is full, stream mode drops the
// new record. Ring and trigger modes overwrite the oldest record instead. Trigger
// mode captures the trigger record plus PostTrigCnt further retirements, then
// freezes the buffer.
module cve2_rvfi_trace_fifo #(
    parameter int unsigned Depth       = 16,
    parameter int unsigned CntWidth    = 16,
    parameter int unsigned PostTrigCnt = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       rvfi_valid_i,
    input  logic [31:0]                rvfi_pc_rdata_i,
    input  logic [31:0]                rvfi_insn_i,
    input  logic                       rvfi_trap_i,
    input  logic                       rvfi_intr_i,
    input  logic [4:0]                 rvfi_rd_addr_i,
    input  logic [31:0]                rvfi_rd_wdata_i,
    input  logic [1:0]                 cfg_mode_i,
    input  logic                       cfg_trig_trap_i,
    input  logic                       arm_i,
    input  logic                       trig_i,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [31:0]                trace_pc_o,
    output logic [31:0]                trace_insn_o,
    output logic [4:0]                 trace_rd_addr_o,
    output logic [31:0]                trace_rd_wdata_o,
    output logic                       trace_trap_o,
    output logic                       trace_intr_o,
    output logic [$clog2(Depth):0]     level_o,
    output logic [CntWidth-1:0]        overflow_cnt_o,
    output logic [1:0]                 state_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_POST, S_FROZEN} state_e;
    typedef enum logic [1:0] {M_OFF, M_STREAM, M_RING, M_TRIG} mode_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        trap;
        logic        intr;
    } record_t;

    state_e                state_q, state_d;
    mode_e                 mode_q;
    logic [AW-1:0]         remain_q, remain_d;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic [CntWidth-1:0]   overflow_q;
    record_t               mem [Depth];
    record_t               wr_rec, head;

    logic push, pop, full, over, do_write, adv_rd, trig_hit;

    // Capture is live only in RUN/POST. An arm in the same cycle discards the retirement.
    assign push     = rvfi_valid_i & ((state_q == S_RUN) | (state_q == S_POST)) & ~arm_i;
    assign pop      = trace_valid_o & trace_ready_i;
    assign full     = (level_q == LW'(Depth));
    assign over     = push & full & ~pop;
    assign do_write = push & (~over | (mode_q != M_STREAM));
    assign adv_rd   = pop | (over & (mode_q != M_STREAM));
    assign trig_hit = push & (trig_i | (cfg_trig_trap_i & rvfi_trap_i));

    assign wr_rec = '{pc: rvfi_pc_rdata_i, insn: rvfi_insn_i, rd_addr: rvfi_rd_addr_i,
                      rd_wdata: rvfi_rd_wdata_i, trap: rvfi_trap_i, intr: rvfi_intr_i};

    // Level changes only when exactly one of push or pop takes effect on a non-full FIFO.
    always_comb begin
        level_d = level_q;
        if (push && !pop && !full) level_d = level_q + 1'b1;
        else if (pop && !push)     level_d = level_q - 1'b1;
    end

    // Capture-window FSM: next state and post-trigger countdown.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d  = state_q;
        remain_d = remain_q;
        unique case (state_q)
            S_RUN: begin
                if (mode_q == M_TRIG && trig_hit) begin
                    if (PostTrigCnt == 0) begin
                        state_d = S_FROZEN;
                    end else begin
                        state_d  = S_POST;
                        remain_d = AW'(PostTrigCnt);
                    end
                end
            end
            S_POST: begin
                if (push) begin
                    remain_d = remain_q - 1'b1;
                    if (remain_q == AW'(1)) state_d = S_FROZEN;
                end
            end
            default: ;
        endcase
        if (arm_i) begin
            state_d  = (mode_e'(cfg_mode_i) == M_OFF) ? S_IDLE : S_RUN;
            remain_d = '0;
        end
    end

    // FSM, mode latch, pointers, level and saturating overflow counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            mode_q     <= M_OFF;
            remain_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            if (arm_i) begin
                mode_q     <= mode_e'(cfg_mode_i);
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                level_q    <= '0;
                overflow_q <= '0;
            end else begin
                if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (adv_rd)   rd_ptr_q <= rd_ptr_q + 1'b1;
                level_q <= level_d;
                if (over && overflow_q != '1) overflow_q <= overflow_q + 1'b1;
            end
        end
    end

    // Record storage write port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; an empty level makes its contents unobservable.
        if (do_write) mem[wr_ptr_q] <= wr_rec;
    end

    assign head             = mem[rd_ptr_q];
    assign trace_valid_o    = (level_q != '0);
    assign trace_pc_o       = trace_valid_o ? head.pc       : '0;
    assign trace_insn_o     = trace_valid_o ? head.insn     : '0;
    assign trace_rd_addr_o  = trace_valid_o ? head.rd_addr  : '0;
    assign trace_rd_wdata_o = trace_valid_o ? head.rd_wdata : '0;
    assign trace_trap_o     = trace_valid_o & head.trap;
    assign trace_intr_o     = trace_valid_o & head.intr;
    assign level_o          = level_q;
    assign overflow_cnt_o   = overflow_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_cve2_rvfi_trace_fifo.sv
// Directed self-checking bench for cve2_rvfi_trace_fifo.
// A second instance (PostTrigCnt 0, 3-bit counter) covers the trap trigger and
// counter saturation.
module tb_cve2_rvfi_trace_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rvfi_valid, rvfi_trap, rvfi_intr, cfg_trig_trap, arm, trig, trace_ready;
    logic [31:0] rvfi_pc, rvfi_insn, rvfi_wdata;
    logic [4:0]  rvfi_rd_addr;
    logic [1:0]  cfg_mode;

    logic        trace_valid, trace_trap, trace_intr;
    logic [31:0] trace_pc, trace_insn, trace_wdata;
    logic [4:0]  trace_rd_addr, level;
    logic [15:0] overflow;
    logic [1:0]  state;

    logic        b_valid, b_trap, b_intr;
    logic [31:0] b_pc, b_insn, b_wdata;
    logic [4:0]  b_rd_addr, b_level;
    logic [2:0]  b_overflow;
    logic [1:0]  b_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cve2_rvfi_trace_fifo dut (
        .clk_i(clk), .rst_ni(rst_n), .rvfi_valid_i(rvfi_valid), .rvfi_pc_rdata_i(rvfi_pc),
        .rvfi_insn_i(rvfi_insn), .rvfi_trap_i(rvfi_trap), .rvfi_intr_i(rvfi_intr),
        .rvfi_rd_addr_i(rvfi_rd_addr), .rvfi_rd_wdata_i(rvfi_wdata), .cfg_mode_i(cfg_mode),
        .cfg_trig_trap_i(cfg_trig_trap), .arm_i(arm), .trig_i(trig),
        .trace_valid_o(trace_valid), .trace_ready_i(trace_ready), .trace_pc_o(trace_pc),
        .trace_insn_o(trace_insn), .trace_rd_addr_o(trace_rd_addr),
        .trace_rd_wdata_o(trace_wdata), .trace_trap_o(trace_trap), .trace_intr_o(trace_intr),
        .level_o(level), .overflow_cnt_o(overflow), .state_o(state)
    );

    cve2_rvfi_trace_fifo #(.Depth(16), .CntWidth(3), .PostTrigCnt(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .rvfi_valid_i(rvfi_valid), .rvfi_pc_rdata_i(rvfi_pc),
        .rvfi_insn_i(rvfi_insn), .rvfi_trap_i(rvfi_trap), .rvfi_intr_i(rvfi_intr),
        .rvfi_rd_addr_i(rvfi_rd_addr), .rvfi_rd_wdata_i(rvfi_wdata), .cfg_mode_i(cfg_mode),
        .cfg_trig_trap_i(cfg_trig_trap), .arm_i(arm), .trig_i(trig),
        .trace_valid_o(b_valid), .trace_ready_i(trace_ready), .trace_pc_o(b_pc),
        .trace_insn_o(b_insn), .trace_rd_addr_o(b_rd_addr),
        .trace_rd_wdata_o(b_wdata), .trace_trap_o(b_trap), .trace_intr_o(b_intr),
        .level_o(b_level), .overflow_cnt_o(b_overflow), .state_o(b_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic trap, input logic trg);
        rvfi_valid   = 1'b1;
        rvfi_pc      = pc;
        rvfi_insn    = ~pc;
        rvfi_trap    = trap;
        rvfi_rd_addr = pc[4:0];
        rvfi_wdata   = pc ^ 32'h0000_a5a5;
        trig         = trg;
        tick();
        rvfi_valid   = 1'b0;
        rvfi_trap    = 1'b0;
        trig         = 1'b0;
    endtask

    task automatic arm_mode(input logic [1:0] mode, input logic trig_trap);
        cfg_mode      = mode;
        cfg_trig_trap = trig_trap;
        arm           = 1'b1;
        tick();
        arm           = 1'b0;
    endtask

    // Pops n records from the primary instance, expecting PCs first, first+step, ...
    task automatic drain_check(input int first, input int step, input int n);
        logic [31:0] exp_pc;
        trace_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            exp_pc = 32'(first + k * step);
            check("drain_valid", {63'd0, trace_valid}, 64'd1);
            check("drain_pc", {32'd0, trace_pc}, {32'd0, exp_pc});
            check("drain_insn", {32'd0, trace_insn}, {32'd0, ~exp_pc});
            tick();
        end
        trace_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rvfi_valid = 0; rvfi_pc = 0; rvfi_insn = 0; rvfi_trap = 0; rvfi_intr = 0;
        rvfi_rd_addr = 0; rvfi_wdata = 0; cfg_mode = 0; cfg_trig_trap = 0; arm = 0; trig = 0;
        trace_ready = 0;
        #12;
        check("rst_valid", {63'd0, trace_valid}, 64'd0);
        check("rst_level", {59'd0, level}, 64'd0);
        check("rst_overflow", {48'd0, overflow}, 64'd0);
        check("rst_state", {62'd0, state}, 64'd0);
        check("rst_pc", {32'd0, trace_pc}, 64'd0);
        rst_n = 1'b1;
        tick();

        // IDLE ignores retirements.
        retire(32'h10, 0, 0);
        check("idle_level", {59'd0, level}, 64'd0);

        // Stream: 20 retirements, ready low -> 16 kept, 4 dropped, oldest preserved.
        arm_mode(2'd1, 0);
        check("stream_state", {62'd0, state}, 64'd1);
        retire(32'd0, 0, 0);
        check("latency_valid", {63'd0, trace_valid}, 64'd1);
        for (int i = 1; i < 20; i++) retire(32'(i), 0, 0);
        check("stream_level", {59'd0, level}, 64'd16);
        check("stream_overflow", {48'd0, overflow}, 64'd4);
        check("b_stream_overflow", {61'd0, b_overflow}, 64'd4);
        drain_check(0, 1, 16);
        check("stream_empty", {63'd0, trace_valid}, 64'd0);

        // Ring: 20 retirements PC=4*i -> oldest 4 overwritten.
        arm_mode(2'd2, 0);
        check("ring_arm_overflow", {48'd0, overflow}, 64'd0);
        for (int i = 0; i < 20; i++) retire(32'(4 * i), 0, 0);
        check("ring_level", {59'd0, level}, 64'd16);
        check("ring_overflow", {48'd0, overflow}, 64'd4);
        drain_check(16, 4, 16);
        check("ring_empty", {59'd0, level}, 64'd0);

        // Full FIFO, push and pop in the same cycle.
        arm_mode(2'd1, 0);
        for (int i = 0; i < 16; i++) retire(32'(100 + i), 0, 0);
        trace_ready = 1'b1;
        retire(32'd200, 0, 0);
        trace_ready = 1'b0;
        check("fullpp_level", {59'd0, level}, 64'd16);
        check("fullpp_overflow", {48'd0, overflow}, 64'd0);
        drain_check(101, 1, 15);
        check("fullpp_last_pc", {32'd0, trace_pc}, 64'd200);
        check("fullpp_last_wdata", {32'd0, trace_wdata}, {32'd0, 32'd200 ^ 32'h0000_a5a5});

        // Trigger: trig on 30th of 40, PostTrigCnt 8 -> frozen after 38th.
        arm_mode(2'd3, 0);
        check("trig_level_after_arm", {59'd0, level}, 64'd0);
        for (int i = 1; i <= 40; i++) begin
            retire(32'(i), 0, i == 30);
            if (i == 29) check("trig_run", {62'd0, state}, 64'd1);
            if (i == 30) check("trig_post", {62'd0, state}, 64'd2);
            if (i == 37) check("trig_post37", {62'd0, state}, 64'd2);
            if (i == 38) check("trig_frozen", {62'd0, state}, 64'd3);
        end
        check("trig_level", {59'd0, level}, 64'd16);
        check("trig_overflow", {48'd0, overflow}, 64'd22);
        drain_check(23, 1, 16);
        check("trig_drained", {59'd0, level}, 64'd0);
        check("trig_still_frozen", {62'd0, state}, 64'd3);

        // Arm in the middle of POST with 5 records held.
        arm_mode(2'd3, 0);
        for (int i = 0; i < 3; i++) retire(32'(i), 0, 0);
        retire(32'd3, 0, 1);
        retire(32'd4, 0, 0);
        check("midpost_state", {62'd0, state}, 64'd2);
        check("midpost_level", {59'd0, level}, 64'd5);
        arm_mode(2'd3, 0);
        check("rearm_level", {59'd0, level}, 64'd0);
        check("rearm_overflow", {48'd0, overflow}, 64'd0);
        check("rearm_state", {62'd0, state}, 64'd1);
        retire(32'h55, 0, 0);
        check("rearm_capture_level", {59'd0, level}, 64'd1);
        check("rearm_capture_pc", {32'd0, trace_pc}, 64'h55);

        // Retirement coincident with arm is discarded.
        rvfi_valid = 1'b1;
        rvfi_pc    = 32'h66;
        arm_mode(2'd1, 0);
        rvfi_valid = 1'b0;
        check("arm_discard_level", {59'd0, level}, 64'd0);

        // Trap trigger on the PostTrigCnt=0 instance.
        arm_mode(2'd3, 1);
        retire(32'h70, 0, 0);
        retire(32'h71, 0, 0);
        retire(32'h72, 0, 0);
        check("trap_run", {62'd0, b_state}, 64'd1);
        retire(32'h77, 1, 0);
        check("trap_frozen", {62'd0, b_state}, 64'd3);
        retire(32'h78, 0, 0);
        check("trap_level", {59'd0, b_level}, 64'd4);
        trace_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("trap_drain_trapbit", {63'd0, b_trap}, 64'd0);
            tick();
        end
        check("trap_last_pc", {32'd0, b_pc}, 64'h77);
        check("trap_last_trapbit", {63'd0, b_trap}, 64'd1);
        tick();
        trace_ready = 1'b0;
        check("trap_empty", {63'd0, b_valid}, 64'd0);

        // Saturating 3-bit counter: 25 retirements in stream mode -> 9 drops, saturates at 7.
        arm_mode(2'd1, 0);
        for (int i = 0; i < 25; i++) retire(32'(i), 0, 0);
        check("sat_b_overflow", {61'd0, b_overflow}, 64'd7);
        check("sat_overflow", {48'd0, overflow}, 64'd9);

        // Reset mid-operation clears everything.
        rst_n = 1'b0;
        #2;
        check("midrst_level", {59'd0, level}, 64'd0);
        check("midrst_valid", {63'd0, trace_valid}, 64'd0);
        check("midrst_overflow", {48'd0, overflow}, 64'd0);
        check("midrst_state", {62'd0, state}, 64'd0);
        rst_n = 1'b1;
        tick();
        retire(32'h99, 0, 0);
        check("postrst_idle_level", {59'd0, level}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
